branch_resolve: RTL and testbench

Branch/jump resolution stage for the RISC-V core. It consumes the 3-bit comparison flags produced by the branch-condition comparator, together with the decoded control-transfer type, funct3, PC, immediate and rs1. It decides taken/not-taken, computes the target and link address, and drives a held redirect handshake toward the fetch unit. It sits between execute and fetch, and keeps wrapping branch/taken statistics counters.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/branch_taken_dec.sv | 42 ++++
 rtl/branch_resolve.sv | 149 ++++++++++++++
 tb/tb_branch_resolve.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the branch resolution stage.
//   - funct3 encodings of the conditional branches
//   - bit positions inside the comparator flag vector
//   - state type of the resolution FSM
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned COND_EQ  = 2;
  localparam int unsigned COND_SGT = 1;
  localparam int unsigned COND_UGT = 0;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_taken_dec.sv
// branch_taken_dec: combinational branch condition decoder.
// Ports:
//   funct3_i  - branch condition select
//   cond_i    - comparator flags {A==B, A>B signed, A>B unsigned}
//   taken_o   - condition holds
//   illegal_o - funct3 is not a defined branch encoding
module branch_taken_dec
  import riscv_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [2:0] cond_i,
  output logic       taken_o,
  output logic       illegal_o
);

  logic eq_s;
  logic sgt_s;
  logic ugt_s;

  assign eq_s  = cond_i[COND_EQ];
  assign sgt_s = cond_i[COND_SGT];
  assign ugt_s = cond_i[COND_UGT];

  // Decode the branch condition; "less than" is neither equal nor greater.
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq_s;
      F3_BNE:  taken_o = ~eq_s;
      F3_BLT:  taken_o = ~eq_s & ~sgt_s;
      F3_BGE:  taken_o = eq_s | sgt_s;
      F3_BLTU: taken_o = ~eq_s & ~ugt_s;
      F3_BGEU: taken_o = eq_s | ugt_s;
      default: begin
        taken_o   = 1'b0;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: branch/jump resolution between execute and fetch.
// Decides taken/not-taken, computes target and link address, issues a held
// redirect toward fetch and keeps wrapping branch/taken statistics.
// Ports:
//   CLK, RST                    - clock, synchronous active-high reset
//   in_valid / in_ready         - operation handshake (ready only in IDLE)
//   is_branch/is_jal/is_jalr    - control-transfer type (jalr > jal > branch)
//   funct3, cond                - branch condition select and comparator flags
//   pc, imm, rs1                - operands for target / link computation
//   res_valid, res_taken,
//   link_pc, misalign, illegal  - per-operation result, one-cycle pulse
//   redirect_valid/_pc/_ready   - redirect handshake toward fetch
//   br_count, taken_count       - wrapping statistics counters
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [2:0]       cond,
  input  logic [31:0]      pc,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  output logic             res_valid,
  output logic             res_taken,
  output logic [31:0]      link_pc,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             misalign,
  output logic             illegal,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  br_state_e        state_q;
  logic             res_valid_q;
  logic             res_taken_q;
  logic [31:0]      link_pc_q;
  logic [31:0]      redirect_pc_q;
  logic             misalign_q;
  logic             illegal_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] taken_count_q;

  logic        dec_taken_s;
  logic        dec_illegal_s;
  logic        sel_br_s;
  logic        taken_s;
  logic        illegal_s;
  logic        misalign_s;
  logic        go_redirect_s;
  logic [31:0] target_s;

  branch_taken_dec u_dec (
    .funct3_i  (funct3),
    .cond_i    (cond),
    .taken_o   (dec_taken_s),
    .illegal_o (dec_illegal_s)
  );

  // Resolve type priority, target address and alignment for the offered op.
  always_comb begin
    sel_br_s      = 1'b0;
    taken_s       = 1'b0;
    illegal_s     = 1'b0;
    target_s      = pc + imm;
    if (is_jalr) begin
      taken_s  = 1'b1;
      target_s = (rs1 + imm) & ~32'h0000_0001;
    end else if (is_jal) begin
      taken_s  = 1'b1;
    end else if (is_branch) begin
      sel_br_s  = 1'b1;
      taken_s   = dec_taken_s;
      illegal_s = dec_illegal_s;
    end else begin
      taken_s  = 1'b0;
    end
    // A taken target with bit 1 set is reported instead of redirected.
    misalign_s    = taken_s & target_s[1];
    go_redirect_s = taken_s & ~target_s[1];
  end

  // Resolution FSM with registered results, redirect and counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      link_pc_q     <= 32'h0000_0000;
      redirect_pc_q <= 32'h0000_0000;
      misalign_q    <= 1'b0;
      illegal_q     <= 1'b0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      res_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            res_valid_q <= 1'b1;
            res_taken_q <= taken_s;
            link_pc_q   <= pc + 32'd4;
            misalign_q  <= misalign_s;
            illegal_q   <= illegal_s;
            if (sel_br_s) begin
              br_count_q <= br_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
              if (taken_s) begin
                taken_count_q <= taken_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end
            if (go_redirect_s) begin
              redirect_pc_q <= target_s;
              state_q       <= ST_REDIRECT;
            end
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == ST_IDLE);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign link_pc        = link_pc_q;
  assign redirect_pc    = redirect_pc_q;
  assign misalign       = misalign_q;
  assign illegal        = illegal_q;
  assign br_count       = br_count_q;
  assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             is_branch = 1'b0;
  logic             is_jal = 1'b0;
  logic             is_jalr = 1'b0;
  logic [2:0]       funct3 = 3'b000;
  logic [2:0]       cond = 3'b000;
  logic [31:0]      pc = 32'h0;
  logic [31:0]      imm = 32'h0;
  logic [31:0]      rs1 = 32'h0;
  logic             res_valid;
  logic             res_taken;
  logic [31:0]      link_pc;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ready = 1'b0;
  logic             misalign;
  logic             illegal;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  int n_vec = 0;
  int n_err = 0;
  int m_br  = 0;
  int m_tk  = 0;

  branch_resolve #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .cond(cond), .pc(pc), .imm(imm), .rs1(rs1),
    .res_valid(res_valid), .res_taken(res_taken), .link_pc(link_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .misalign(misalign), .illegal(illegal),
    .br_count(br_count), .taken_count(taken_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
    return 32'(v % (1 << CNT_W));
  endfunction

  // Offer one operation whose comparator flags come from operands a and bb;
  // the expected outcome is derived from the ISA meaning of each branch.
  task automatic issue(input logic b, input logic j, input logic jr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] bb, input logic [31:0] p,
                       input logic [31:0] im, input logic [31:0] r1,
                       input int stall, input bit no_handshake);
    logic tk, il, isb, mis, redir;
    logic [31:0] tgt;
    tk = 1'b0; il = 1'b0; isb = 1'b0;
    tgt = p + im;
    if (jr) begin
      tk = 1'b1;
      tgt = (r1 + im) & 32'hFFFF_FFFE;
    end else if (j) begin
      tk = 1'b1;
    end else if (b) begin
      isb = 1'b1;
      case (f3)
        3'd0: tk = (a == bb);
        3'd1: tk = (a != bb);
        3'd4: tk = ($signed(a) < $signed(bb));
        3'd5: tk = ($signed(a) >= $signed(bb));
        3'd6: tk = (a < bb);
        3'd7: tk = (a >= bb);
        default: begin tk = 1'b0; il = 1'b1; end
      endcase
    end
    mis   = tk && tgt[1];
    redir = tk && !tgt[1];
    if (isb) begin
      m_br++;
      if (tk) m_tk++;
    end
    chk("in_ready_pre", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; is_branch = b; is_jal = j; is_jalr = jr;
    funct3 = f3; cond = {a == bb, $signed(a) > $signed(bb), a > bb};
    pc = p; imm = im; rs1 = r1;
    redirect_ready = (stall == 0);
    @(posedge CLK); #1;
    in_valid = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    chk("res_valid", {31'd0, res_valid}, 32'd1);
    chk("res_taken", {31'd0, res_taken}, {31'd0, tk});
    chk("link_pc", link_pc, p + 32'd4);
    chk("misalign", {31'd0, misalign}, {31'd0, mis});
    chk("illegal", {31'd0, illegal}, {31'd0, il});
    chk("br_count", {28'd0, br_count}, cnt_exp(m_br));
    chk("taken_count", {28'd0, taken_count}, cnt_exp(m_tk));
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, redir});
    chk("in_ready_post", {31'd0, in_ready}, {31'd0, !redir});
    if (redir) begin
      chk("redirect_pc", redirect_pc, tgt);
      for (int k = 0; k < stall; k++) begin
        redirect_ready = 1'b0;
        in_valid = 1'b1; is_branch = 1'b1; funct3 = 3'd1; cond = 3'b000;
        pc = $urandom;
        @(posedge CLK); #1;
        in_valid = 1'b0; is_branch = 1'b0;
        chk("hold_valid", {31'd0, redirect_valid}, 32'd1);
        chk("hold_pc", redirect_pc, tgt);
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        chk("hold_res_valid", {31'd0, res_valid}, 32'd0);
        chk("hold_br_count", {28'd0, br_count}, cnt_exp(m_br));
      end
      if (!no_handshake) begin
        redirect_ready = 1'b1;
        @(posedge CLK); #1;
        redirect_ready = 1'b0;
        chk("hs_valid", {31'd0, redirect_valid}, 32'd0);
        chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("hs_res_valid", {31'd0, res_valid}, 32'd0);
      end
    end
    redirect_ready = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge CLK); #1;
    chk("idle_res_valid", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_link_pc"}, link_pc, 32'd0);
    chk({tag, "_br_count"}, {28'd0, br_count}, 32'd0);
    chk({tag, "_taken_count"}, {28'd0, taken_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rp, ri;
    int ty;
    // Reset
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state("reset");
    chk("reset_res_taken", {31'd0, res_taken}, 32'd0);
    chk("reset_misalign", {31'd0, misalign}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // BEQ taken, redirect accepted immediately
    issue(1'b1, 1'b0, 1'b0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 32'h0, 0, 1'b0);
    // BLTU not taken (A>B unsigned), then back-to-back BLT with only A>B signed
    issue(1'b1, 1'b0, 1'b0, 3'd6, 32'h8000_0000, 32'h0, 32'h200, 32'h8, 32'h0, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 3'd4, 32'h1, 32'h8000_0000, 32'h204, 32'h8, 32'h0, 0, 1'b0);
    // BGE with A>B signed, BLT with all flags clear: both taken
    issue(1'b1, 1'b0, 1'b0, 3'd5, 32'h1, 32'h8000_0000, 32'h300, 32'h10, 32'h0, 1, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 3'd4, 32'h0, 32'h1, 32'h400, 32'hFFFF_FFF8, 32'h0, 2, 1'b0);
    // JALR held for three cycles with in_valid offered meanwhile
    issue(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h500, 32'h4, 32'h1001, 3, 1'b0);
    // JALR landing on 0x1006 has bit 1 set: misaligned, no redirect
    issue(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h600, 32'h4, 32'h1003, 0, 1'b0);
    // JAL misaligned, then an illegal funct3 branch, then a no-type op
    issue(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h6, 32'h0, 0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 3'd2, 32'h7, 32'h7, 32'h700, 32'h40, 32'h0, 0, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 3'd0, 32'h7, 32'h7, 32'h800, 32'h40, 32'h0, 0, 1'b0);
    // Type priority: all types set resolves as JALR
    issue(1'b1, 1'b1, 1'b1, 3'd1, 32'h7, 32'h7, 32'h900, 32'h8, 32'h2000, 1, 1'b0);
    idle_cycle();

    // Randomised operations
    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb ^ 32'h8000_0000;
      rp = $urandom & 32'hFFFF_FFFC;
      ri = $urandom;
      ty = $urandom_range(0, 5);
      issue(ty >= 2, ty == 1, ty == 0 || (ty == 5 && $urandom_range(0, 1) == 1),
            3'($urandom_range(0, 7)), ra, rb, rp, ri, $urandom,
            $urandom_range(0, 3), 1'b0);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    // Counter wrap: 15 branches reach all-ones, the 16th wraps to zero
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    m_br = 0; m_tk = 0;
    check_reset_state("rst2");
    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      rb = $urandom;
      issue(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), ra, rb,
            32'h1000, 32'h2, 32'h0, 0, 1'b0);
      if (n == 14) chk("br_all_ones", {28'd0, br_count}, 32'd15);
    end
    chk("br_wrap", {28'd0, br_count}, 32'd0);

    // Reset during a held redirect, with accept and ready also offered
    issue(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h40, 32'h100, 32'h0, 1, 1'b1);
    RST = 1'b1; redirect_ready = 1'b1;
    in_valid = 1'b1; is_jal = 1'b1; pc = 32'h80; imm = 32'h40;
    @(posedge CLK); #1;
    RST = 1'b0; redirect_ready = 1'b0; in_valid = 1'b0; is_jal = 1'b0;
    m_br = 0; m_tk = 0;
    check_reset_state("rst_redirect");
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
